// File: rtl/cpu_ctl_pkg.sv
// Shared constants, opcode classes and state encoding for the CPU control sequencer.
package cpu_ctl_pkg;

  // Opcodes (IR[31:27])
  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  // ALU codes used outside of ALU instructions
  localparam logic [4:0] ALU_ADD   = 5'd3;
  localparam logic [4:0] ALU_INCPC = 5'd31;

  // IR field positions
  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_HI = 22;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_HI = 18;
  localparam int IR_RC_LO = 15;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT, FAULT
  } ctlState_t;

  // Execute-phase behaviour groups; anything unlisted behaves as nop.
  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU, CLS_MULDIV, CLS_LDI, CLS_LD, CLS_ST, CLS_HALT
  } opClass_t;

  function automatic opClass_t classifyOp(input logic [4:0] op);
    opClass_t c;
    c = CLS_NOP;
    if (op >= OP_ADD && op <= OP_ROL)         c = CLS_ALU;
    else if (op == OP_MUL || op == OP_DIV)    c = CLS_MULDIV;
    else if (op == OP_LDI)                    c = CLS_LDI;
    else if (op == OP_LD)                     c = CLS_LD;
    else if (op == OP_ST)                     c = CLS_ST;
    else if (op == OP_HALT)                   c = CLS_HALT;
    return c;
  endfunction

endpackage

// File: rtl/ctl_reg_decode.sv
// 4-bit register field to one-hot R0..R15 strobe, all zero when disabled.
module ctl_reg_decode (
  input  logic [3:0]  field,
  input  logic        en,
  output logic [15:0] oneHot
);

  // Plain one-hot decode; R0 gets no special treatment
  always_comb begin
    oneHot = '0;
    if (en) oneHot[field] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle controller for the single-bus CPU datapath.
// Outputs are a combinational function of state, IR and mem_ack.
module control_sequencer
  import cpu_ctl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ack,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic        PCin,
  output logic        PCout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDR_read,
  output logic        c_sign_extended_out,
  output logic [4:0]  control,
  output logic        mem_read,
  output logic        mem_write,
  output logic        done,
  output logic        halted,
  output logic        fault
);

  ctlState_t   state, stateNext;
  logic [31:0] waitCnt;
  logic        isReq, waitExpired, firstCycle;
  logic        raIn, raOut, rbOut, rcOut;
  logic [15:0] raHot, rbHot, rcHot;
  logic [4:0]  opcode;
  opClass_t    cls;
  ctlState_t   afterDone;
  logic        unusedIrBits;

  assign opcode       = ir[IR_OP_HI:IR_OP_LO];
  assign cls          = classifyOp(opcode);
  assign afterDone    = run ? T0 : IDLE;
  assign firstCycle   = (waitCnt == '0);
  assign waitExpired  = (MEM_TIMEOUT != 0) && ((waitCnt + 32'd1) >= 32'(MEM_TIMEOUT));
  assign unusedIrBits = ^ir[14:0];

  ctl_reg_decode raDec (.field(ir[IR_RA_HI:IR_RA_LO]), .en(raIn | raOut), .oneHot(raHot));
  ctl_reg_decode rbDec (.field(ir[IR_RB_HI:IR_RB_LO]), .en(rbOut),        .oneHot(rbHot));
  ctl_reg_decode rcDec (.field(ir[IR_RC_HI:IR_RC_LO]), .en(rcOut),        .oneHot(rcHot));

  // Ra is the only field that can be both a destination and a bus source
  assign reg_in  = raIn  ? raHot : 16'd0;
  assign reg_out = (raOut ? raHot : 16'd0) | rbHot | rcHot;

  // State register and memory wait counter (cleared whenever the state moves on)
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state <= stateNext;
      if (isReq && !mem_ack && stateNext == state)
        waitCnt <= (waitCnt == '1) ? waitCnt : waitCnt + 32'd1;
      else
        waitCnt <= '0;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    stateNext           = state;
    isReq               = 1'b0;
    raIn                = 1'b0;
    raOut               = 1'b0;
    rbOut               = 1'b0;
    rcOut               = 1'b0;
    HIin                = 1'b0;
    HIout               = 1'b0;
    LOin                = 1'b0;
    LOout               = 1'b0;
    PCin                = 1'b0;
    PCout               = 1'b0;
    IRin                = 1'b0;
    Yin                 = 1'b0;
    Zin                 = 1'b0;
    Zhighout            = 1'b0;
    Zlowout             = 1'b0;
    MARin               = 1'b0;
    MDRin               = 1'b0;
    MDRout              = 1'b0;
    MDR_read            = 1'b0;
    c_sign_extended_out = 1'b0;
    control             = 5'd0;
    mem_read            = 1'b0;
    mem_write           = 1'b0;
    done                = 1'b0;
    halted              = 1'b0;
    fault               = 1'b0;

    unique case (state)
      IDLE: if (run) stateNext = T0;

      T0: begin
        PCout     = 1'b1;
        MARin     = 1'b1;
        control   = ALU_INCPC;
        Zin       = 1'b1;
        stateNext = T1;
      end

      // PC update happens only on entry; the read request then holds until ack
      T1: begin
        isReq    = 1'b1;
        mem_read = 1'b1;
        if (firstCycle) begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
        end
        if (mem_ack) begin
          MDR_read  = 1'b1;
          MDRin     = 1'b1;
          stateNext = T2;
        end else if (waitExpired) begin
          stateNext = FAULT;
        end
      end

      T2: begin
        MDRout    = 1'b1;
        IRin      = 1'b1;
        stateNext = T3;
      end

      T3: begin
        unique case (cls)
          CLS_ALU, CLS_LDI, CLS_LD, CLS_ST: begin
            rbOut     = 1'b1;
            Yin       = 1'b1;
            stateNext = T4;
          end
          CLS_MULDIV: begin
            raOut     = 1'b1;
            Yin       = 1'b1;
            stateNext = T4;
          end
          CLS_HALT: begin
            done      = 1'b1;
            stateNext = HALT;
          end
          default: begin
            done      = 1'b1;
            stateNext = afterDone;
          end
        endcase
      end

      T4: begin
        unique case (cls)
          CLS_ALU: begin
            rcOut     = 1'b1;
            control   = opcode;
            Zin       = 1'b1;
            stateNext = T5;
          end
          CLS_MULDIV: begin
            rbOut     = 1'b1;
            control   = opcode;
            Zin       = 1'b1;
            stateNext = T5;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            c_sign_extended_out = 1'b1;
            control             = ALU_ADD;
            Zin                 = 1'b1;
            stateNext           = T5;
          end
          default: stateNext = IDLE;
        endcase
      end

      T5: begin
        unique case (cls)
          CLS_ALU, CLS_LDI: begin
            Zlowout   = 1'b1;
            raIn      = 1'b1;
            done      = 1'b1;
            stateNext = afterDone;
          end
          CLS_MULDIV: begin
            Zlowout   = 1'b1;
            LOin      = 1'b1;
            stateNext = T6;
          end
          CLS_LD, CLS_ST: begin
            Zlowout   = 1'b1;
            MARin     = 1'b1;
            stateNext = T6;
          end
          default: stateNext = IDLE;
        endcase
      end

      T6: begin
        unique case (cls)
          CLS_MULDIV: begin
            Zhighout  = 1'b1;
            HIin      = 1'b1;
            done      = 1'b1;
            stateNext = afterDone;
          end
          CLS_LD: begin
            isReq    = 1'b1;
            mem_read = 1'b1;
            if (mem_ack) begin
              MDR_read  = 1'b1;
              MDRin     = 1'b1;
              stateNext = T7;
            end else if (waitExpired) begin
              stateNext = FAULT;
            end
          end
          CLS_ST: begin
            raOut     = 1'b1;
            MDRin     = 1'b1;
            stateNext = T7;
          end
          default: stateNext = IDLE;
        endcase
      end

      T7: begin
        unique case (cls)
          CLS_LD: begin
            MDRout    = 1'b1;
            raIn      = 1'b1;
            done      = 1'b1;
            stateNext = afterDone;
          end
          CLS_ST: begin
            isReq     = 1'b1;
            mem_write = 1'b1;
            if (mem_ack) begin
              done      = 1'b1;
              stateNext = afterDone;
            end else if (waitExpired) begin
              stateNext = FAULT;
            end
          end
          default: stateNext = IDLE;
        endcase
      end

      HALT:  halted = 1'b1;
      FAULT: fault  = 1'b1;

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench: a per-instruction micro-step list built from the
// instruction tables is replayed cycle by cycle against the sequencer.
module tb_control_sequencer;

  localparam int TO = 4;

  typedef struct packed {
    logic [5:0]  pad;
    logic [15:0] regIn;
    logic [15:0] regOut;
    logic hiIn, hiOut, loIn, loOut, pcIn, pcOut, irIn, yIn, zIn, zHi, zLo;
    logic marIn, mdrIn, mdrOut, mdrRead, cSext;
    logic [4:0]  ctl;
    logic memRd, memWr, done, halted, fault;
  } outs_t;

  typedef struct {
    outs_t      o;
    logic [1:0] ackMode;   // 0: drive 0, 1: drive 1, 2: random (ack ignored)
  } step_t;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        run = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] reg_in, reg_out;
  logic HIin, HIout, LOin, LOout, PCin, PCout, IRin, Yin, Zin, Zhighout, Zlowout;
  logic MARin, MDRin, MDRout, MDR_read, c_sign_extended_out;
  logic [4:0] control;
  logic mem_read, mem_write, done, halted, fault;
  logic [63:0] obs;

  int total = 0;
  int bad   = 0;
  step_t q[$];
  bit terminal;

  control_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ack(mem_ack),
    .reg_in(reg_in), .reg_out(reg_out),
    .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
    .PCin(PCin), .PCout(PCout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .MDR_read(MDR_read),
    .c_sign_extended_out(c_sign_extended_out), .control(control),
    .mem_read(mem_read), .mem_write(mem_write), .done(done),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  assign obs = {6'd0, reg_in, reg_out, HIin, HIout, LOin, LOout, PCin, PCout, IRin,
                Yin, Zin, Zhighout, Zlowout, MARin, MDRin, MDRout, MDR_read,
                c_sign_extended_out, control, mem_read, mem_write, done, halted, fault};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] hot(input logic [3:0] f);
    logic [15:0] v;
    v = 16'd1;
    return v << f;
  endfunction

  task automatic push(input outs_t o, input logic [1:0] am);
    step_t s;
    s.o = o;
    s.ackMode = am;
    q.push_back(s);
  endtask

  // One memory request: d wait cycles then the ack cycle; or, with toFault,
  // TO unanswered cycles followed by the sticky fault state.
  task automatic memPhase(input bit wr, input int d, input bit toFault, input bit mdrOnAck,
                          input bit doneOnAck, input bit zOnFirst);
    outs_t o;
    int n;
    n = toFault ? TO : d + 1;
    for (int k = 0; k < n; k++) begin
      o = '0;
      if (wr) o.memWr = 1'b1; else o.memRd = 1'b1;
      if (zOnFirst && k == 0) begin o.zLo = 1'b1; o.pcIn = 1'b1; end
      if (!toFault && k == d) begin
        if (mdrOnAck)  begin o.mdrRead = 1'b1; o.mdrIn = 1'b1; end
        if (doneOnAck) o.done = 1'b1;
      end
      push(o, (!toFault && k == d) ? 2'd1 : 2'd0);
    end
    if (toFault) begin
      for (int k = 0; k < 3; k++) begin
        o = '0; o.fault = 1'b1; push(o, 2'd2);
      end
    end
  endtask

  // Expected cycle-by-cycle outputs for one instruction starting at T0
  task automatic buildSeq(input logic [31:0] iv, input int d1, input int d2, input bit toFault);
    outs_t o;
    logic [4:0] op;
    logic [15:0] ra, rb, rc;
    op = iv[31:27];
    ra = hot(iv[26:23]);
    rb = hot(iv[22:19]);
    rc = hot(iv[18:15]);
    q.delete();
    terminal = toFault;
    o = '0; o.pcOut = 1; o.marIn = 1; o.ctl = 5'd31; o.zIn = 1; push(o, 2'd2);
    memPhase(1'b0, d1, 1'b0, 1'b1, 1'b0, 1'b1);
    o = '0; o.mdrOut = 1; o.irIn = 1; push(o, 2'd2);
    if (op >= 5'd3 && op <= 5'd10) begin
      o = '0; o.regOut = rb; o.yIn = 1; push(o, 2'd2);
      o = '0; o.regOut = rc; o.ctl = op; o.zIn = 1; push(o, 2'd2);
      o = '0; o.zLo = 1; o.regIn = ra; o.done = 1; push(o, 2'd2);
    end else if (op == 5'd15 || op == 5'd16) begin
      o = '0; o.regOut = ra; o.yIn = 1; push(o, 2'd2);
      o = '0; o.regOut = rb; o.ctl = op; o.zIn = 1; push(o, 2'd2);
      o = '0; o.zLo = 1; o.loIn = 1; push(o, 2'd2);
      o = '0; o.zHi = 1; o.hiIn = 1; o.done = 1; push(o, 2'd2);
    end else if (op <= 5'd2) begin
      o = '0; o.regOut = rb; o.yIn = 1; push(o, 2'd2);
      o = '0; o.cSext = 1; o.ctl = 5'd3; o.zIn = 1; push(o, 2'd2);
      if (op == 5'd1) begin
        o = '0; o.zLo = 1; o.regIn = ra; o.done = 1; push(o, 2'd2);
      end else begin
        o = '0; o.zLo = 1; o.marIn = 1; push(o, 2'd2);
        if (op == 5'd0) begin
          memPhase(1'b0, d2, toFault, 1'b1, 1'b0, 1'b0);
          if (!toFault) begin
            o = '0; o.mdrOut = 1; o.regIn = ra; o.done = 1; push(o, 2'd2);
          end
        end else begin
          o = '0; o.regOut = ra; o.mdrIn = 1; push(o, 2'd2);
          memPhase(1'b1, d2, toFault, 1'b0, 1'b1, 1'b0);
        end
      end
    end else if (op == 5'd27) begin
      o = '0; o.done = 1; push(o, 2'd2);
      for (int k = 0; k < 4; k++) begin
        o = '0; o.halted = 1; push(o, 2'd2);
      end
      terminal = 1'b1;
    end else begin
      o = '0; o.done = 1; push(o, 2'd2);
    end
  endtask

  // Replays q from T0 (entered at posedge+1). stopAt>=0 pulses clr in that step.
  // Non-terminal sequences leave the DUT in T0 again.
  task automatic runSeq(input string nm, input logic [31:0] iv, input bit nextRun, input int stopAt);
    ir = iv;
    for (int i = 0; i < q.size(); i++) begin
      if (terminal) run = 1'b1;
      else if (i == q.size() - 1) run = nextRun;
      else run = 1'($urandom);
      mem_ack = (q[i].ackMode == 2'd2) ? 1'($urandom) : q[i].ackMode[0];
      if (i == stopAt) begin
        clr = 1'b0;
        #1 chk($sformatf("%s_rstNow", nm), obs, 64'd0);
        run = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("%s_rstHeld", nm), obs, 64'd0);
        clr = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("%s_rstIdle", nm), obs, 64'd0);
        run = 1'b1;
        @(posedge clk); #1;
        return;
      end
      #1 chk($sformatf("%s_s%0d", nm, i), obs, 64'(q[i].o));
      @(posedge clk); #1;
    end
    if (!terminal && !nextRun) begin
      chk($sformatf("%s_idle", nm), obs, 64'd0);
      run = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic doReset(input string nm);
    clr = 1'b0;
    run = 1'b0;
    mem_ack = 1'b0;
    #1 chk($sformatf("%s_rst", nm), obs, 64'd0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("%s_idle", nm), obs, 64'd0);
    run = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] iv;
    logic [4:0]  op;
    @(posedge clk); #1;
    doReset("start");

    // add R5,R2,R4: reset mid-T4, then a full run
    buildSeq(32'h1A920000, 0, 0, 1'b0);
    runSeq("addRst", 32'h1A920000, 1'b1, 4);
    buildSeq(32'h1A920000, 0, 0, 1'b0);
    runSeq("add", 32'h1A920000, 1'b1, -1);

    // mul R3,R1
    iv = {5'd15, 4'd3, 4'd1, 4'd0, 15'd0};
    buildSeq(iv, 0, 0, 1'b0);
    runSeq("mul", iv, 1'b1, -1);

    // ld R1 with 3 wait cycles on the data read
    iv = {5'd0, 4'd1, 4'd7, 4'd0, 15'h1234};
    buildSeq(iv, 0, 3, 1'b0);
    runSeq("ld", iv, 1'b1, -1);

    // random instruction stream with random waits and run drops
    for (int n = 0; n < 60; n++) begin
      op = 5'($urandom);
      if (op == 5'd27) op = 5'd26;
      iv = {op, 27'($urandom)};
      buildSeq(iv, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      runSeq($sformatf("r%0d", n), iv, (n == 59) ? 1'b1 : 1'($urandom), -1);
    end

    // st with no ack ever: timeout to FAULT
    iv = {5'd2, 4'd6, 4'd2, 4'd0, 15'h0010};
    buildSeq(iv, 1, 0, 1'b1);
    runSeq("stTo", iv, 1'b1, -1);
    doReset("afterFault");

    // halt with run held high
    iv = {5'd27, 27'd0};
    buildSeq(iv, 0, 0, 1'b0);
    runSeq("halt", iv, 1'b1, -1);
    doReset("afterHalt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
